// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM and owner encodings,
// default widths and a counter-width helper.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } arb_owner_t;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;

    // Bits needed to hold the values 0..max inclusive.
    function automatic int ctr_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Starvation guard: counts CPU grants taken while the DMA is waiting and
// forces a DMA grant once STARVE_MAX of them have happened in a row.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_grant,
    input  logic dma_grant,
    input  logic dma_req,
    output logic force_dma
);

    localparam int              CW   = ctr_w(STARVE_MAX);
    localparam logic [CW-1:0]   MAXV = CW'(STARVE_MAX);

    logic [CW-1:0] r_cnt;

    // Saturating count of CPU wins over a waiting DMA; any DMA win, or a CPU
    // win with no DMA contention, restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (dma_grant) begin
            r_cnt <= '0;
        end else if (cpu_grant) begin
            if (!dma_req)
                r_cnt <= '0;
            else if (r_cnt != MAXV)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign force_dma = (r_cnt == MAXV);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage and a DMA/loader.
// IDLE latches one request, ISSUE drives the memory for one cycle, RESP
// returns the ack (and read data) to the owner, then back to IDLE.
// Build option: DMEM_ARB_STARVE_GUARD_EN enables the DMA starvation guard;
// without it the CPU has strict priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    // CPU port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    // DMA port
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    // memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state, w_next;
    arb_owner_t        r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic w_idle, w_grant_any, w_grant_dma, w_force_dma;
    logic w_issue, w_resp;

    assign w_idle      = (r_state == IDLE);
    assign w_grant_any = w_idle && (cpu_req || dma_req);
    // CPU wins ties unless the guard says the DMA has waited long enough.
    assign w_grant_dma = w_idle && dma_req && (!cpu_req || w_force_dma);

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic w_cpu_grant;
    assign w_cpu_grant = w_grant_any && !w_grant_dma;

    dmem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .cpu_grant (w_cpu_grant),
        .dma_grant (w_grant_dma),
        .dma_req   (dma_req),
        .force_dma (w_force_dma)
    );
`else
    // Strict CPU priority: the DMA is never forced in (expression is always 0).
    assign w_force_dma = (STARVE_MAX < 0);
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next state: one cycle each in ISSUE and RESP, IDLE waits for a request.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (cpu_req || dma_req) w_next = ISSUE;
            ISSUE:   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Capture the granted request so the memory sees stable fields in ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= OWN_CPU;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant_any) begin
            if (w_grant_dma) begin
                r_owner <= OWN_DMA;
                r_we    <= dma_we;
                r_addr  <= dma_addr;
                r_wdata <= dma_wdata;
            end else begin
                r_owner <= OWN_CPU;
                r_we    <= cpu_we;
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
            end
        end
    end

    // Reset gates the strobes so an in-flight write or ack is dropped at once.
    assign w_issue = (r_state == ISSUE) && !reset;
    assign w_resp  = (r_state == RESP)  && !reset;

    // Memory side: everything is zero outside the ISSUE cycle.
    always_comb begin
        mem_en    = w_issue;
        mem_we    = w_issue && r_we;
        mem_addr  = w_issue ? r_addr  : '0;
        mem_wdata = w_issue ? r_wdata : '0;
    end

    // Requester side: ack to the owner in RESP, read data only for reads.
    always_comb begin
        cpu_ack   = w_resp && (r_owner == OWN_CPU);
        dma_ack   = w_resp && (r_owner == OWN_DMA);
        cpu_rdata = (cpu_ack && !r_we) ? mem_rdata : '0;
        dma_rdata = (dma_ack && !r_we) ? mem_rdata : '0;
    end

    assign cpu_stall = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack, cpu_stall;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic [31:0] dma_rdata;
    logic        dma_ack;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic        dma_rd_nz = 1'b0;
    logic        mon_clr = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // memory model: sync read, data valid the cycle after mem_en
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    // sticky monitor of any non-zero dma_rdata
    always @(negedge clk) begin
        if (mon_clr) dma_rd_nz <= 1'b0;
        else if (dma_rdata !== 32'h0) dma_rd_nz <= 1'b1;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    // Run one access on a port; lat = cycles from req to ack, -1 on timeout.
    task automatic access(input bit dma, input bit we, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output int lat);
        rd = '0; lat = -1;
        if (dma) begin dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = d; end
        else     begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dma ? dma_ack : cpu_ack) begin
                rd = dma ? dma_rdata : cpu_rdata; lat = c; break;
            end
        end
        step();
        cpu_req = 0; dma_req = 0;
    endtask

    task automatic test_reset();
        reset = 1; cpu_req = 1;
        step(); step();
        @(negedge clk);
        tests++;
        if ({cpu_ack, dma_ack, mem_en, mem_we} !== 4'b0) begin
            fails++; $display("FAIL reset_strobes got %b want 0000", {cpu_ack, dma_ack, mem_en, mem_we});
        end
        tests++;
        if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== 128'h0) begin
            fails++; $display("FAIL reset_buses got %h want 0", {mem_addr, mem_wdata, cpu_rdata, dma_rdata});
        end
        tests++;
        if (cpu_stall !== 1'b1) begin
            fails++; $display("FAIL reset_stall got %b want 1", cpu_stall);
        end
        step();
        cpu_req = 0; reset = 0;
        @(negedge clk);
        tests++;
        if (cpu_stall !== 1'b0) begin
            fails++; $display("FAIL reset_stall_low got %b want 0", cpu_stall);
        end
        step();
    endtask

    task automatic test_cpu_read();
        preload(8'h10, 32'hDEADBEEF);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        @(negedge clk); // cycle 0
        tests++;
        if ({mem_en, cpu_ack, cpu_stall} !== 3'b001) begin
            fails++; $display("FAIL rd_c0 en/ack/stall got %b want 001", {mem_en, cpu_ack, cpu_stall});
        end
        step(); @(negedge clk); // cycle 1
        tests++;
        if ({mem_en, mem_we, cpu_ack, cpu_stall} !== 4'b1001 || mem_addr !== 32'h10) begin
            fails++; $display("FAIL rd_c1 en/we/ack/stall got %b addr %h want 1001 addr 10",
                              {mem_en, mem_we, cpu_ack, cpu_stall}, mem_addr);
        end
        step(); @(negedge clk); // cycle 2
        tests++;
        if ({mem_en, cpu_ack, cpu_stall} !== 3'b010 || cpu_rdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL rd_c2 en/ack/stall got %b rdata %h want 010 deadbeef",
                              {mem_en, cpu_ack, cpu_stall}, cpu_rdata);
        end
        step(); cpu_req = 0; @(negedge clk); // cycle 3
        tests++;
        if (cpu_ack !== 1'b0 || cpu_rdata !== 32'h0) begin
            fails++; $display("FAIL rd_c3 ack %b rdata %h want 0 0", cpu_ack, cpu_rdata);
        end
        step();
    endtask

    task automatic test_dma_then_cpu();
        logic [31:0] rd; int lat;
        mon_clr = 1; @(negedge clk); #1; mon_clr = 0; step();
        access(1'b1, 1'b1, 32'h20, 32'h12345678, rd, lat);
        tests++;
        if (lat != 2) begin fails++; $display("FAIL dma_wr_lat got %0d want 2", lat); end
        tests++;
        if (mem[8'h20] !== 32'h12345678) begin
            fails++; $display("FAIL dma_wr_mem got %h want 12345678", mem[8'h20]);
        end
        access(1'b0, 1'b0, 32'h20, 32'h0, rd, lat);
        tests++;
        if (rd !== 32'h12345678 || lat != 2) begin
            fails++; $display("FAIL cpu_rd_after_dma got %h lat %0d want 12345678 lat 2", rd, lat);
        end
        tests++;
        if (dma_rd_nz !== 1'b0) begin fails++; $display("FAIL dma_rdata_zero got nonzero want 0"); end
    endtask

    task automatic test_simultaneous();
        int cack = -1, den = -1, dack = -1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'h55;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (cpu_ack && cack < 0) cack = c;
            if (mem_en && mem_addr == 32'h40 && den < 0) den = c;
            if (dma_ack && dack < 0) dack = c;
            step();
            if (cack >= 0) cpu_req = 0;
            if (dack >= 0) dma_req = 0;
        end
        tests++;
        if (cack != 2 || den != 4 || dack != 5) begin
            fails++; $display("FAIL simult cpu_ack@%0d dma_en@%0d dma_ack@%0d want 2 4 5", cack, den, dack);
        end
        tests++;
        if (mem[8'h40] !== 32'h55) begin fails++; $display("FAIL simult_mem got %h want 55", mem[8'h40]); end
    endtask

    task automatic test_req_held();
        int n = 0; logic [31:0] mask = '0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (cpu_ack) begin n++; mask[c] = 1'b1; end
            step();
        end
        cpu_req = 0;
        tests++;
        if (n != 3 || mask !== 32'h124) begin
            fails++; $display("FAIL req_held acks %0d mask %h want 3 124", n, mask);
        end
        step(); step();
    endtask

    task automatic test_starve();
        int nc = 0, nd = 0, k = 0;
        logic [9:0] seq = '0, exp_seq;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        dma_req = 1; dma_we = 0; dma_addr = 32'h20;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (cpu_ack) begin nc++; k++; end
            if (dma_ack) begin nd++; if (k < 10) seq[k] = 1'b1; k++; end
            step();
        end
        cpu_req = 0; dma_req = 0;
        step(); step(); step(); step();
`ifdef DMEM_ARB_STARVE_GUARD_EN
        exp_seq = 10'b10000_10000;
        tests++;
        if (seq !== exp_seq) begin fails++; $display("FAIL starve_seq got %b want %b", seq, exp_seq); end
        tests++;
        if (nd != 6 || nc != 27) begin fails++; $display("FAIL starve_cnt cpu %0d dma %0d want 27 6", nc, nd); end
`else
        exp_seq = 10'b0;
        tests++;
        if (seq !== exp_seq || nd != 0) begin fails++; $display("FAIL nostarve_dma got %0d want 0", nd); end
        tests++;
        if (nc != 33) begin fails++; $display("FAIL nostarve_cpu got %0d want 33", nc); end
`endif
    endtask

    task automatic test_reset_mid_write();
        int acks = 0, ens = 0;
        logic [31:0] rd; int lat;
        preload(8'h30, 32'h0BADF00D);
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'hAAAAAAAA;
        step(); reset = 1; // cycle 1 = ISSUE
        @(negedge clk);
        tests++;
        if ({mem_en, mem_we} !== 2'b00) begin
            fails++; $display("FAIL rst_issue en/we got %b want 00", {mem_en, mem_we});
        end
        step(); reset = 0; cpu_req = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (cpu_ack) acks++;
            if (mem_en) ens++;
            step();
        end
        tests++;
        if (acks != 0 || ens != 0) begin fails++; $display("FAIL rst_no_ack acks %0d ens %0d want 0 0", acks, ens); end
        tests++;
        if (mem[8'h30] !== 32'h0BADF00D) begin fails++; $display("FAIL rst_mem got %h want 0badf00d", mem[8'h30]); end
        access(1'b0, 1'b0, 32'h30, 32'h0, rd, lat);
        tests++;
        if (lat != 2 || rd !== 32'h0BADF00D) begin
            fails++; $display("FAIL rst_then_rd lat %0d rd %h want 2 0badf00d", lat, rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_cpu_read();
        test_dma_then_cpu();
        test_simultaneous();
        test_req_held();
        test_starve();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port synchronous data memory between the pipelined CPU's MEM-stage port and a DMA/loader port. A small FSM latches one request, issues it to memory for one cycle, returns read data with a one-cycle ack, and drives a stall to the CPU while its access is outstanding. The block sits between the CPU/DMA masters and the memory array, replacing the direct CPU-to-memory connection.

## Interface
Parameters:
- ADDR_W, 32, address width (byte address, passed through unmodified)
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive CPU grants tolerated while DMA waits (starvation guard only)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data, valid only while cpu_ack is high on a read
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req && !cpu_ack, used to freeze the pipeline
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack  same directions, widths and meaning as the cpu_* ports
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en

## Operation
FSM states:
- IDLE: samples the requests.
  - If any request is pending, latches owner, we, addr and wdata; goes to ISSUE.
  - Otherwise stays in IDLE.
- ISSUE: drives mem_en=1, mem_we, mem_addr and mem_wdata from the latched registers for exactly one cycle; goes to RESP.
- RESP: pulses the owner's ack; goes to IDLE.
  - On a read, the owner's rdata equals mem_rdata.
  - On a write, rdata is 0.

Handshake and arbitration:
- Requests are sampled only in IDLE. A requester must keep req and its fields stable until ack, and drops req on the edge where ack is high.
- If req is still high in IDLE, it is a new access.
- Both requests in IDLE: the CPU wins (fixed priority), except when the starvation guard forces a DMA grant.
- A req asserted during ISSUE or RESP waits for IDLE.

Outputs:
- mem_* outputs are 0 in every state except ISSUE.
- rdata outputs are 0 except in RESP for a read.
- Address and data pass through unmodified; there are no width conversions.

## Timing
- Reset values: state IDLE; cpu_ack, dma_ack, mem_en, mem_we 0; mem_addr, mem_wdata, cpu_rdata, dma_rdata 0; latched registers and starvation counter 0. cpu_stall follows cpu_req.
- Latency: req high in cycle N (state IDLE) -> mem_en in N+1 -> ack and rdata in N+2.
  - Minimum issue interval per access is 3 cycles.
  - Back-to-back throughput is one access per 3 cycles.
- cpu_stall is combinational and is high in cycles N and N+1.
- Reset mid-operation: reset high in any cycle forces IDLE at the next edge.
  - mem_en and mem_we are gated by reset, so an ISSUE-cycle write coinciding with reset is dropped.
  - A pending ack is not generated. Requesters re-request after reset.
- Simultaneous events: a new request cannot be accepted in a RESP cycle. After RESP the block always returns to IDLE for one cycle.

## Configuration
- DMEM_ARB_STARVE_GUARD_EN defined:
  - A counter increments on each CPU grant taken while dma_req is high.
  - It clears on every DMA grant, and on a CPU grant when dma_req is low.
  - When the counter equals STARVE_MAX and both requests are present, the DMA is granted.
  - The counter saturates and never wraps.
- Undefined: strict CPU priority; the counter logic is absent and the DMA may starve indefinitely.

## Structure
- Shared package/header dmem_arb_pkg:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, RESP=2'd2
  - owner encoding: OWN_CPU=1'b0, OWN_DMA=1'b1
  - default widths
- One sub-module, dmem_arb_starve_ctr: a saturating counter with inputs cpu_grant, dma_grant, dma_req and output force_dma. It is instantiated only under DMEM_ARB_STARVE_GUARD_EN.

## Test plan
- CPU read: mem preloaded [0x10]=0xDEADBEEF; cpu_req with addr 0x10 at cycle 0 -> mem_en at cycle 1, cpu_ack=1 and cpu_rdata=0xDEADBEEF at cycle 2; cpu_stall high for cycles 0–1.
- DMA write then CPU read: dma writes 0x1234_5678 to 0x20, then CPU reads 0x20 -> cpu_rdata=0x12345678; dma_rdata stays 0 throughout.
- Simultaneous requests: both req at cycle 0 -> CPU acked at cycle 2, DMA mem_en at cycle 4, dma_ack at cycle 5.
- Starvation guard: guard enabled, STARVE_MAX=4, cpu_req and dma_req held continuously -> 4 CPU acks, then 1 DMA ack, repeating. With the guard disabled -> 0 DMA acks over 100 cycles.
- Reset mid-write: assert reset during the ISSUE cycle of a CPU write of 0xAAAA_AAAA to 0x30 -> mem_en=0 that cycle, [0x30] unchanged, cpu_ack never pulses, state IDLE.
- Req held after ack: cpu_req held high for 9 cycles -> exactly 3 acks at cycles 2, 5 and 8.
